// File: rtl/mem_bus_arbiter.sv
// ============================================================================
// mem_bus_arbiter
// ----------------------------------------------------------------------------
// Shares the single line-wide downstream memory bus between the instruction
// cache (port I) and the data cache (port D). The winning request is latched
// into a register that drives the memory side. The memory response is steered
// back to the owner of the grant.
//
// Build option:
//   MEM_ARB_RR_EN  defined   : round-robin. A tie goes to the port opposite
//                              to the previous owner (grant_d).
//                  undefined : fixed priority. D always wins a tie.
//
// Parameters:
//   TIMEOUT_CYCLES : number of GRANT cycles before bus_timeout sets.
//                    0 disables the watchdog.
//
// Ports:
//   clk          in   clock, all state changes on the rising edge
//   rst_n        in   asynchronous active-low reset
//   i_req        in   ICache request (mem_bus_req_t)
//   i_resp       out  ICache response (mem_bus_resp_t)
//   d_req        in   DCache request (mem_bus_req_t)
//   d_resp       out  DCache response (mem_bus_resp_t)
//   mem_req      out  registered request towards memory
//   mem_resp     in   memory response
//   bus_timeout  out  sticky watchdog flag
//   grant_d      out  owner of the current or last grant (1 = D, 0 = I)
// ============================================================================

package mem_bus_pkg;

    // 64-byte line request: 2 command flags + 58-bit address + 512-bit data.
    typedef struct packed {
        logic         req_load;
        logic         req_store;
        logic [57:0]  req_addr;
        logic [511:0] req_data;
    } mem_bus_req_t;

    // Response: ready strobe + 512-bit line data.
    typedef struct packed {
        logic         mem_ready;
        logic [511:0] mem_data;
    } mem_bus_resp_t;

endpackage

module mem_bus_arbiter
    import mem_bus_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic          clk,
    input  logic          rst_n,
    input  mem_bus_req_t  i_req,
    output mem_bus_resp_t i_resp,
    input  mem_bus_req_t  d_req,
    output mem_bus_resp_t d_resp,
    output mem_bus_req_t  mem_req,
    input  mem_bus_resp_t mem_resp,
    output logic          bus_timeout,
    output logic          grant_d
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t       r_state;
    state_t       w_state_next;
    mem_bus_req_t r_mem_req;
    mem_bus_req_t w_mem_req_next;
    logic         r_grant_d;
    logic         w_grant_d_next;
    logic [15:0]  r_wait_cnt;
    logic [15:0]  w_wait_cnt_next;
    logic [15:0]  w_cnt_inc;
    logic         r_bus_timeout;
    logic         w_bus_timeout_next;
    logic         w_timeout_hit;

    logic         w_i_pend;
    logic         w_d_pend;
    logic         w_pick_d;
    logic         w_in_grant;
    logic         w_i_ready;
    logic         w_d_ready;

    assign w_i_pend = i_req.req_load | i_req.req_store;
    assign w_d_pend = d_req.req_load | d_req.req_store;

    // Winner selection, only meaningful when at least one port is pending.
`ifdef MEM_ARB_RR_EN
    // D wins if it is alone, or on a tie when I owned the last grant.
    assign w_pick_d = w_d_pend & (~w_i_pend | ~r_grant_d);
`else
    // D wins whenever it is pending.
    assign w_pick_d = w_d_pend;
`endif

    // Saturating wait-counter increment.
    assign w_cnt_inc = (r_wait_cnt == 16'hFFFF) ? r_wait_cnt : r_wait_cnt + 16'd1;

    generate
        if (TIMEOUT_CYCLES != 0) begin : g_wdog
            // Thresholds beyond the counter range clamp to the saturation value.
            localparam logic [15:0] C_TIMEOUT =
                (TIMEOUT_CYCLES > 65535) ? 16'hFFFF : 16'(TIMEOUT_CYCLES);
            assign w_timeout_hit = (w_cnt_inc >= C_TIMEOUT);
        end else begin : g_no_wdog
            assign w_timeout_hit = 1'b0;
        end
    endgenerate

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_next       = r_state;
        w_mem_req_next     = r_mem_req;
        w_grant_d_next     = r_grant_d;
        w_wait_cnt_next    = r_wait_cnt;
        w_bus_timeout_next = r_bus_timeout;

        case (r_state)
            ST_IDLE: begin
                if (w_i_pend | w_d_pend) begin
                    w_state_next    = ST_GRANT;
                    w_mem_req_next  = w_pick_d ? d_req : i_req;
                    w_grant_d_next  = w_pick_d;
                    w_wait_cnt_next = 16'd0;
                end
            end
            ST_GRANT: begin
                if (mem_resp.mem_ready) begin
                    w_state_next    = ST_DONE;
                    w_mem_req_next  = '0;
                    w_wait_cnt_next = 16'd0;
                end else begin
                    w_wait_cnt_next = w_cnt_inc;
                    // Flag only; the transaction keeps waiting for memory.
                    if (w_timeout_hit) begin
                        w_bus_timeout_next = 1'b1;
                    end
                end
            end
            // One dead cycle so the finished requester can drop its request
            // before the next arbitration.
            ST_DONE: begin
                w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= ST_IDLE;
            r_mem_req     <= '0;
            // Pointing at D makes the first round-robin tie go to I.
            r_grant_d     <= 1'b1;
            r_wait_cnt    <= 16'd0;
            r_bus_timeout <= 1'b0;
        end else begin
            r_state       <= w_state_next;
            r_mem_req     <= w_mem_req_next;
            r_grant_d     <= w_grant_d_next;
            r_wait_cnt    <= w_wait_cnt_next;
            r_bus_timeout <= w_bus_timeout_next;
        end
    end

    // ------------------------------------------------------------------------
    // Response steering: data goes to both ports, ready only to the owner and
    // only while a grant is outstanding, so strays in IDLE/DONE are dropped.
    // ------------------------------------------------------------------------
    assign w_in_grant = (r_state == ST_GRANT);
    assign w_i_ready  = w_in_grant & ~r_grant_d & mem_resp.mem_ready;
    assign w_d_ready  = w_in_grant &  r_grant_d & mem_resp.mem_ready;

    assign i_resp      = {w_i_ready, mem_resp.mem_data};
    assign d_resp      = {w_d_ready, mem_resp.mem_data};
    assign mem_req     = r_mem_req;
    assign bus_timeout = r_bus_timeout;
    assign grant_d     = r_grant_d;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// ============================================================================
// tb_mem_bus_arbiter
// ----------------------------------------------------------------------------
// Directed bench for mem_bus_arbiter. Two instances share the same stimulus:
// u_dut uses an 8-cycle watchdog, u_dut0 has the watchdog disabled.
// Inputs change 1 time unit after the rising edge; outputs are sampled on the
// falling edge. Expectations for tie ordering follow MEM_ARB_RR_EN.
// ============================================================================

module tb_mem_bus_arbiter;
    import mem_bus_pkg::*;

    logic          clk = 1'b0;
    logic          rst_n;
    mem_bus_req_t  i_req;
    mem_bus_req_t  d_req;
    mem_bus_resp_t mem_resp;

    mem_bus_resp_t i_resp, d_resp, i_resp0, d_resp0;
    mem_bus_req_t  mem_req, mem_req0;
    logic          bus_timeout, grant_d, bus_timeout0, grant_d0;

    int checks = 0;
    int errors = 0;
    int seed_n = 0;

    always #5 clk = ~clk;

    mem_bus_arbiter #(.TIMEOUT_CYCLES(8)) u_dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_req       (i_req),
        .i_resp      (i_resp),
        .d_req       (d_req),
        .d_resp      (d_resp),
        .mem_req     (mem_req),
        .mem_resp    (mem_resp),
        .bus_timeout (bus_timeout),
        .grant_d     (grant_d)
    );

    mem_bus_arbiter #(.TIMEOUT_CYCLES(0)) u_dut0 (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_req       (i_req),
        .i_resp      (i_resp0),
        .d_req       (d_req),
        .d_resp      (d_resp0),
        .mem_req     (mem_req0),
        .mem_resp    (mem_resp),
        .bus_timeout (bus_timeout0),
        .grant_d     (grant_d0)
    );

    function automatic mem_bus_req_t mk_req(input logic ld, input logic st,
                                            input logic [57:0] addr);
        mem_bus_req_t r;
        r.req_load  = ld;
        r.req_store = st;
        r.req_addr  = addr;
        r.req_data  = {16{addr[31:0] ^ 32'h5A5A_0F0F}};
        return r;
    endfunction

    task automatic chk_bit(input string tag, input logic got, input logic exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, got, exp);
        end
    endtask

    task automatic chk_req(input string tag, input mem_bus_req_t got,
                           input mem_bus_req_t exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic chk_data(input string tag, input logic [511:0] got,
                            input logic [511:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // Runs one transaction. Entered at posedge+1 of an IDLE cycle with the
    // requests already applied; returns at posedge+1 of the following IDLE
    // cycle with the winner's request dropped.
    task automatic txn(input logic exp_d, input mem_bus_req_t exp_req,
                       input int lat, input string tag);
        logic [511:0] data;
        data = {16{32'hD00D_0000 + 32'(seed_n)}};
        seed_n++;
        @(negedge clk);
        chk_req({tag, "_idle_req"}, mem_req, '0);
        @(posedge clk); #1;
        for (int c = 1; c <= lat; c++) begin
            mem_resp.mem_ready = (c == lat);
            mem_resp.mem_data  = data;
            @(negedge clk);
            chk_req({tag, "_grant_req"}, mem_req, exp_req);
            chk_bit({tag, "_grant_d"}, grant_d, exp_d);
            chk_bit({tag, "_i_ready"}, i_resp.mem_ready, (c == lat) && !exp_d);
            chk_bit({tag, "_d_ready"}, d_resp.mem_ready, (c == lat) && exp_d);
            if (c == lat) begin
                chk_data({tag, "_i_data"}, i_resp.mem_data, data);
                chk_data({tag, "_d_data"}, d_resp.mem_data, data);
                chk_req({tag, "_req_wd0"}, mem_req0, exp_req);
            end
            @(posedge clk); #1;
        end
        // DONE cycle: requester drops its request.
        mem_resp.mem_ready = 1'b0;
        if (exp_d) d_req = '0;
        else       i_req = '0;
        @(negedge clk);
        chk_req({tag, "_done_req"}, mem_req, '0);
        chk_bit({tag, "_done_i_ready"}, i_resp.mem_ready, 1'b0);
        chk_bit({tag, "_done_d_ready"}, d_resp.mem_ready, 1'b0);
        @(posedge clk); #1;
        $display("TXN %s owner=%s addr=%h latency=%0d", tag, exp_d ? "D" : "I",
                 exp_req.req_addr, lat);
    endtask

    mem_bus_req_t r_i1, r_i2, r_d1, r_d2, r_a, r_t, r_r, r_b1, r_b2;

    initial begin
        i_req    = '0;
        d_req    = '0;
        mem_resp = '0;
        rst_n    = 1'b1;
        r_i1 = mk_req(1'b1, 1'b0, 58'h2000);
        r_i2 = mk_req(1'b1, 1'b0, 58'h2040);
        r_d1 = mk_req(1'b1, 1'b1, 58'h3000);  // both flags: forwarded unchanged
        r_d2 = mk_req(1'b0, 1'b1, 58'h3040);
        r_a  = mk_req(1'b1, 1'b0, 58'h1000);
        r_t  = mk_req(1'b0, 1'b1, 58'h7000);
        r_r  = mk_req(1'b1, 1'b0, 58'h5000);
        r_b1 = mk_req(1'b1, 1'b0, 58'h9000);
        r_b2 = mk_req(1'b1, 1'b0, 58'h9040);

        // ---------------- reset state ----------------
        #3 rst_n = 1'b0;
        #1;
        chk_req("rst_mem_req", mem_req, '0);
        chk_bit("rst_timeout", bus_timeout, 1'b0);
        chk_bit("rst_grant_d", grant_d, 1'b1);
        chk_bit("rst_i_ready", i_resp.mem_ready, 1'b0);
        chk_bit("rst_d_ready", d_resp.mem_ready, 1'b0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // ---------------- simultaneous I and D, 4-cycle latency ----------------
        i_req = r_i1;
        d_req = r_d1;
`ifdef MEM_ARB_RR_EN
        txn(1'b0, r_i1, 4, "tie_1");
        i_req = r_i2;
        txn(1'b1, r_d1, 4, "tie_2");
        d_req = r_d2;
        txn(1'b0, r_i2, 4, "tie_3");
        txn(1'b1, r_d2, 4, "tie_4");
`else
        txn(1'b1, r_d1, 4, "tie_1");
        d_req = r_d2;
        txn(1'b1, r_d2, 4, "tie_2");
        txn(1'b0, r_i1, 4, "tie_3");
        i_req = r_i2;
        txn(1'b0, r_i2, 4, "tie_4");
`endif

        // ---------------- single I load, zero wait, stray readies ----------------
        i_req = r_a;
        @(negedge clk);
        chk_req("single_idle_req", mem_req, '0);
        @(posedge clk); #1;
        mem_resp = {1'b1, {16{32'h1234_ABCD}}};
        @(negedge clk);
        chk_req("single_grant_req", mem_req, r_a);
        chk_bit("single_i_ready", i_resp.mem_ready, 1'b1);
        chk_bit("single_i_ready_wd0", i_resp0.mem_ready, 1'b1);
        chk_bit("single_d_ready", d_resp.mem_ready, 1'b0);
        chk_data("single_i_data", i_resp.mem_data, {16{32'h1234_ABCD}});
        chk_bit("single_grant_d", grant_d, 1'b0);
        @(posedge clk); #1;
        i_req = '0;                      // DONE; mem_ready left high as a stray
        @(negedge clk);
        chk_req("single_done_req", mem_req, '0);
        chk_bit("stray_done_i_ready", i_resp.mem_ready, 1'b0);
        chk_bit("stray_done_d_ready", d_resp.mem_ready, 1'b0);
        @(posedge clk); #1;              // IDLE, stray still high
        @(negedge clk);
        chk_bit("stray_idle_i_ready", i_resp.mem_ready, 1'b0);
        chk_bit("stray_idle_d_ready", d_resp.mem_ready, 1'b0);
        chk_req("stray_idle_req", mem_req, '0);
        @(posedge clk); #1;
        mem_resp = '0;
        @(negedge clk);
        chk_req("stray_after_req", mem_req, '0);
        @(posedge clk); #1;

        // ---------------- watchdog: D store, memory silent ----------------
        d_req = r_t;
        @(negedge clk);
        chk_req("wd_idle_req", mem_req, '0);
        @(posedge clk); #1;
        for (int g = 1; g <= 10; g++) begin
            @(negedge clk);
            chk_bit($sformatf("wd_timeout_g%0d", g), bus_timeout, g >= 9);
            chk_req($sformatf("wd_req_g%0d", g), mem_req, r_t);
            @(posedge clk); #1;
        end
        chk_bit("wd0_timeout_wait", bus_timeout0, 1'b0);
        mem_resp.mem_ready = 1'b1;
        @(negedge clk);
        chk_bit("wd_d_ready", d_resp.mem_ready, 1'b1);
        chk_bit("wd0_d_ready", d_resp0.mem_ready, 1'b1);
        chk_bit("wd_timeout_ready", bus_timeout, 1'b1);
        @(posedge clk); #1;
        mem_resp.mem_ready = 1'b0;
        d_req = '0;
        @(negedge clk);
        chk_bit("wd_timeout_sticky", bus_timeout, 1'b1);
        chk_bit("wd0_timeout_never", bus_timeout0, 1'b0);
        chk_req("wd_done_req", mem_req, '0);
        @(posedge clk); #1;

        // ---------------- reset mid-GRANT ----------------
        i_req = r_r;
        @(negedge clk);
        chk_req("mrst_idle_req", mem_req, '0);
        @(posedge clk); #1;
        @(negedge clk);
        chk_req("mrst_grant_req", mem_req, r_r);
        #2;
        mem_resp.mem_ready = 1'b1;
        rst_n = 1'b0;
        #1;
        chk_req("mrst_mem_req", mem_req, '0);
        chk_bit("mrst_i_ready", i_resp.mem_ready, 1'b0);
        chk_bit("mrst_d_ready", d_resp.mem_ready, 1'b0);
        chk_bit("mrst_timeout", bus_timeout, 1'b0);
        chk_bit("mrst_grant_d", grant_d, 1'b1);
        chk_bit("mrst_grant_d_wd0", grant_d0, 1'b1);
        mem_resp.mem_ready = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        txn(1'b0, r_r, 1, "mrst_regrant");

        // ---------------- back-to-back D loads, zero wait ----------------
        d_req = r_b1;
        txn(1'b1, r_b1, 1, "b2b_1");
        d_req = r_b2;
        txn(1'b1, r_b2, 1, "b2b_2");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_bus_arbiter.md
# mem_bus_arbiter

Two-requester arbiter for the single line-wide memory bus (`mem_bus_req_t` / `mem_bus_resp_t`, 64-byte lines). It shares the downstream bus between the instruction cache (port I) and the data cache (port D), registers the granted request and steers the response back to its owner. It sits between the L1 caches and the memory or L2 model, one level below the pipeline.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, default 1024: number of cycles spent waiting in GRANT before `bus_timeout` sets. A value of 0 disables the watchdog.

Ports:
- `clk`  in  1  clock. One clock domain; all state changes on the rising edge.
- `rst_n`  in  1  asynchronous reset, active-low.
- `i_req`  in  572 (`mem_bus_req_t`)  ICache request.
- `i_resp`  out  513 (`mem_bus_resp_t`)  ICache response.
- `d_req`  in  572 (`mem_bus_req_t`)  DCache request.
- `d_resp`  out  513 (`mem_bus_resp_t`)  DCache response.
- `mem_req`  out  572 (`mem_bus_req_t`)  registered request to memory.
- `mem_resp`  in  513 (`mem_bus_resp_t`)  memory response.
- `bus_timeout`  out  1  sticky watchdog flag.
- `grant_d`  out  1  owner of the current or last grant: 1 = D, 0 = I.

## Operation
- A request is pending when `req_load | req_store` is high. A requester holds its whole request stable until it sees `mem_ready` for one cycle, then drops it.
- The FSM has three states: IDLE, GRANT, DONE.
- **IDLE**
  - No pending request: stay in IDLE.
  - One or more pending: pick a winner, latch its request into `mem_req`, set `grant_d`, go to GRANT.
- **GRANT**
  - `mem_req` holds the latched request.
  - The wait counter (16 bit, saturating) increments each cycle.
  - `mem_resp.mem_ready` = 1: go to DONE, clear `mem_req` to all-zero, clear the counter.
- **DONE**
  - Lasts exactly one cycle, then go to IDLE.
  - Purpose: the finished requester drops its request before the next arbitration, so a stale request is never re-granted.
- **Response steering** (combinational):
  - `mem_data` is driven to both `i_resp` and `d_resp`.
  - `mem_ready` reaches only the granted port, and only in GRANT.
  - The non-granted port always sees `mem_ready` = 0.
  - A `mem_ready` arriving in IDLE or DONE is ignored.
- **Request flags**
  - A request with both `req_load` and `req_store` set is forwarded unchanged.
  - The arbiter never splits or reorders a request.
- **Watchdog**
  - Active only when `TIMEOUT_CYCLES` ≠ 0.
  - When the counter reaches `TIMEOUT_CYCLES` in GRANT, `bus_timeout` sets and stays set until reset.
  - The transaction is not aborted; the FSM keeps waiting.
- **Reset** (asynchronous, any state, including mid-GRANT)
  - FSM goes to IDLE.
  - `mem_req`, counter and `bus_timeout` go to 0.
  - `grant_d` goes to 1, so under round-robin the first tie goes to I.
  - `i_resp.mem_ready` and `d_resp.mem_ready` go to 0.
  - An in-flight memory transaction is abandoned; memory is reset alongside.

## Timing
- Request pending in cycle n while in IDLE: `mem_req` is valid from cycle n+1.
- `mem_ready` in cycle k (GRANT): the owner sees `mem_ready` and data in the same cycle k.
- After that completion:
  - `mem_req` is 0 in cycle k+1 (DONE).
  - Cycle k+2 is IDLE and arbitrates.
  - The next `mem_req` is valid at k+3.
- Minimum occupancy is 3 cycles per transaction with zero-wait memory: grant, ready in the first GRANT cycle, DONE.
- A new request arriving during GRANT or DONE waits in its requester. It is never dropped.

## Configuration
- `MEM_ARB_RR_EN` defined: round-robin. On a tie the winner is the port opposite to `grant_d`.
- `MEM_ARB_RR_EN` undefined: fixed priority. D always wins a tie; I is served only when D is idle in IDLE.
- Single-requester behaviour is identical in both builds.

## Test plan
- **Single I load, zero-wait memory.**
  - Stimulus: `i_req` load at addr 0x1000, `mem_ready` on the first GRANT cycle.
  - Required: `mem_req` valid 1 cycle later, `i_resp.mem_ready` = 1 for exactly 1 cycle, `d_resp.mem_ready` = 0, `mem_req` = 0 the following cycle.
- **Simultaneous I and D requests, 4-cycle memory latency.**
  - With `MEM_ARB_RR_EN`: grant order after reset is I, D, I, D.
  - Without `MEM_ARB_RR_EN`: D wins every tie; I is served only after D drops.
- **D store held with `mem_ready` never asserted, `TIMEOUT_CYCLES` = 8.**
  - Required: `bus_timeout` sets after 8 GRANT cycles and stays set after `mem_ready` finally arrives.
  - Repeat with `TIMEOUT_CYCLES` = 0: `bus_timeout` is never set.
- **Stray `mem_ready` pulse in IDLE and in DONE.**
  - Required: neither response port sees `mem_ready`; the FSM state is unchanged.
- **`rst_n` asserted mid-GRANT.**
  - Required: `mem_req` = 0 immediately (asynchronous), both response readies = 0.
  - After release, a pending I request is granted first.
- **Back-to-back D loads, zero-wait memory.**
  - Required: consecutive `mem_req` valid windows are separated by exactly 2 cycles with `mem_req` = 0.
